vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter.sv | 116 +++++++++++
 tb/tb_vga_plot_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Two-requester arbiter for the VGA plot port: burst-limited ownership with a two-cycle dead band
// on every handover. Plot strobe to VGA outputs is one registered cycle; gnt follows req one cycle from IDLE.
module vga_plot_arbiter #(
   parameter int MAX_BURST = 19200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [6:0] y0,
   input  logic [6:0] y1,
   input  logic [2:0] c0,
   input  logic [2:0] c1,
   input  logic       p0,
   input  logic       p1,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

   localparam logic [15:0] LP_MAX = 16'(MAX_BURST);

   state_t      r_state;
   logic [1:0]  r_gnt;
   logic        r_last;
   logic [15:0] r_cnt;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic [2:0]  r_c;
   logic        r_plot;

   logic       w_own, w_sel, w_mine, w_other, w_at_max, w_rotate, w_accept, w_in_range;
   logic [7:0] w_px;
   logic [6:0] w_py;
   logic [2:0] w_pc;
   logic       w_pp;

   assign w_own    = (r_state == OWN0) || (r_state == OWN1);
   assign w_sel    = (r_state == OWN1);
   assign w_px     = w_sel ? x1 : x0;
   assign w_py     = w_sel ? y1 : y0;
   assign w_pc     = w_sel ? c1 : c0;
   assign w_pp     = w_sel ? p1 : p0;
   assign w_mine   = w_sel ? req[1] : req[0];
   assign w_other  = w_sel ? req[0] : req[1];
   assign w_at_max = (r_cnt == LP_MAX);
   // A burst that has hit its limit with a waiter pending issues nothing more before rotating.
   assign w_rotate   = w_own && w_at_max && w_other;
   assign w_accept   = w_own && w_pp && !w_rotate;
   assign w_in_range = (w_px < 8'd160) && (w_py < 7'd120);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_gnt   <= 2'b00;
         r_last  <= 1'b1;
         r_cnt   <= 16'd0;
         r_x     <= 8'd0;
         r_y     <= 7'd0;
         r_c     <= 3'd0;
         r_plot  <= 1'b0;
      end else begin
         r_plot <= w_accept && w_in_range;
         if (w_accept && w_in_range) begin
            r_x <= w_px;
            r_y <= w_py;
            r_c <= w_pc;
         end

         case (r_state)
            IDLE: begin
               if (req == 2'b01 || (req == 2'b11 && r_last)) begin
                  r_state <= OWN0;
                  r_gnt   <= 2'b01;
                  r_last  <= 1'b0;
                  r_cnt   <= 16'd0;
               end else if (req == 2'b10 || (req == 2'b11 && !r_last)) begin
                  r_state <= OWN1;
                  r_gnt   <= 2'b10;
                  r_last  <= 1'b1;
                  r_cnt   <= 16'd0;
               end
            end
            OWN0, OWN1: begin
               if (!w_mine || w_rotate) begin
                  r_state <= GAP;
                  r_gnt   <= 2'b00;
               end else if (w_at_max) begin
                  // Uncontested owner: restart the burst window, counting this cycle's plot.
                  r_cnt <= w_accept ? 16'd1 : 16'd0;
               end else if (w_accept) begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= 2'b00;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign busy       = (r_gnt != 2'b00);
   assign vga_x      = r_x;
   assign vga_y      = r_y;
   assign vga_colour = r_c;
   assign vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with MAX_BURST = 4; expected values are hand-derived.
module tb_vga_plot_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [1:0] gnt;
   logic [7:0] x0 = 8'd0, x1 = 8'd0;
   logic [6:0] y0 = 7'd0, y1 = 7'd0;
   logic [2:0] c0 = 3'd0, c1 = 3'd0;
   logic       p0 = 1'b0, p1 = 1'b0;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   vga_plot_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .c0(c0), .c1(c1), .p0(p0), .p1(p1),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 2'b00; p0 = 1'b0; p1 = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_gnt", 16'(gnt), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
      check("rst_plot", 16'(vga_plot), 16'h0);
      check("rst_xyc", {vga_x, vga_y, 1'b0}, 16'h0);
      check("rst_col", 16'(vga_colour), 16'h0);
      do_reset();

      // single requester, first plot
      req = 2'b01; p0 = 1'b1; x0 = 8'd5; y0 = 7'd7; c0 = 3'd3;
      tick();
      check("s1_gnt", 16'(gnt), 16'h1);
      check("s1_busy", 16'(busy), 16'h1);
      check("s1_noplot_idle", 16'(vga_plot), 16'h0);
      tick();
      check("s1_plot", 16'(vga_plot), 16'h1);
      check("s1_x", 16'(vga_x), 16'd5);
      check("s1_y", 16'(vga_y), 16'd7);
      check("s1_c", 16'(vga_colour), 16'd3);

      // contention from IDLE, voluntary release, non-owner strobe blocked
      do_reset();
      req = 2'b11; p1 = 1'b1; x1 = 8'd9;
      tick();
      check("s2_gnt0", 16'(gnt), 16'h1);
      tick();
      check("s2_nonowner", 16'(vga_plot), 16'h0);
      req = 2'b10; p1 = 1'b0;
      tick();
      check("s2_gap1", 16'(gnt), 16'h0);
      check("s2_gap1_busy", 16'(busy), 16'h0);
      tick();
      check("s2_gap2", 16'(gnt), 16'h0);
      tick();
      check("s2_gnt1", 16'(gnt), 16'h2);

      // forced rotation after MAX_BURST plots
      do_reset();
      req = 2'b11; p0 = 1'b1; x0 = 8'd10; y0 = 7'd20; c0 = 3'd1;
      tick();
      check("s3_gnt0", 16'(gnt), 16'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("s3_plot%0d", i), 16'(vga_plot), 16'h1);
         check($sformatf("s3_own%0d", i), 16'(gnt), 16'h1);
      end
      tick();
      check("s3_stop_plot", 16'(vga_plot), 16'h0);
      check("s3_gap", 16'(gnt), 16'h0);
      tick();
      check("s3_idle", 16'(gnt), 16'h0);
      check("s3_idle_plot", 16'(vga_plot), 16'h0);
      tick();
      check("s3_gnt1", 16'(gnt), 16'h2);

      // uncontested owner keeps plotting past MAX_BURST
      do_reset();
      req = 2'b01; p0 = 1'b1; x0 = 8'd1; y0 = 7'd2; c0 = 3'd4;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("s4_plot%0d", i), 16'(vga_plot), 16'h1);
         check($sformatf("s4_gnt%0d", i), 16'(gnt), 16'h1);
      end

      // screen bounds on the owner's coordinates
      x0 = 8'd160; y0 = 7'd0; c0 = 3'd6;
      tick();
      check("s5_x160_plot", 16'(vga_plot), 16'h0);
      check("s5_x_hold", 16'(vga_x), 16'd1);
      x0 = 8'd0; y0 = 7'd120;
      tick();
      check("s5_y120_plot", 16'(vga_plot), 16'h0);
      x0 = 8'd159; y0 = 7'd119; c0 = 3'd7;
      tick();
      check("s5_edge_plot", 16'(vga_plot), 16'h1);
      check("s5_edge_x", 16'(vga_x), 16'd159);
      check("s5_edge_y", 16'(vga_y), 16'd119);
      check("s5_edge_c", 16'(vga_colour), 16'd7);
      p0 = 1'b0;
      tick();
      check("s5_idle_plot", 16'(vga_plot), 16'h0);
      check("s5_hold_x", 16'(vga_x), 16'd159);

      // asynchronous reset mid OWN1 burst
      do_reset();
      req = 2'b10; p1 = 1'b1; x1 = 8'd33; y1 = 7'd44; c1 = 3'd2;
      tick();
      check("s6_gnt1", 16'(gnt), 16'h2);
      tick();
      check("s6_plot", 16'(vga_plot), 16'h1);
      check("s6_x", 16'(vga_x), 16'd33);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_rst_gnt", 16'(gnt), 16'h0);
      check("s6_rst_plot", 16'(vga_plot), 16'h0);
      check("s6_rst_busy", 16'(busy), 16'h0);
      check("s6_rst_x", 16'(vga_x), 16'd0);
      tick();
      check("s6_held_plot", 16'(vga_plot), 16'h0);
      rst_n = 1'b1;
      req = 2'b11;
      tick();
      check("s6_regnt0", 16'(gnt), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
